// File: rtl/raster_scan_engine.sv
// rtl/raster_scan_engine.sv - W x H raster walker with linear and strip addressing; optional RASTER_SCAN_ROM_ALIGN_EN
`timescale 1ns/1ps
module raster_scan_engine #(
    parameter int H_RES   = 160,
    parameter int V_RES   = 120,
    parameter int X_W     = 8,
    parameter int Y_W     = 7,
    parameter int ADDR_W  = 15,
    parameter int SPLIT_Y = 92,
    parameter int STRIP_W = 13
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               start,
    input  logic               abort,
    input  logic               ready,
    output logic               busy,
    output logic               plot,
    output logic [X_W-1:0]     x,
    output logic [Y_W-1:0]     y,
    output logic [ADDR_W-1:0]  addr,
    output logic               in_strip,
    output logic [STRIP_W-1:0] strip_addr,
    output logic               done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [X_W-1:0]     X_LAST      = X_W'(H_RES - 1);
    localparam logic [Y_W-1:0]     Y_LAST      = Y_W'(V_RES - 1);
    localparam logic [Y_W-1:0]     Y_PRE_SPLIT = Y_W'((SPLIT_Y > 0) ? SPLIT_Y - 1 : 0);
    localparam logic               SPLIT_TOP   = (SPLIT_Y == 0);
    localparam logic [X_W-1:0]     X_ONE       = X_W'(1);
    localparam logic [Y_W-1:0]     Y_ONE       = Y_W'(1);
    localparam logic [ADDR_W-1:0]  A_ONE       = ADDR_W'(1);
    localparam logic [STRIP_W-1:0] S_ONE       = STRIP_W'(1);

    state_t               state;
    state_t               state_next;
    logic [X_W-1:0]       cnt_x;
    logic [Y_W-1:0]       cnt_y;
    logic [ADDR_W-1:0]    cnt_addr;
    logic [STRIP_W-1:0]   cnt_strip;
    logic                 cnt_in;
    logic                 busy_r;
    logic                 last_px;
    logic                 start_ok;
    logic                 done_exit;

    assign last_px = (cnt_x == X_LAST) && (cnt_y == Y_LAST);

`ifdef RASTER_SCAN_ROM_ALIGN_EN
    logic                 plot_q;
    logic                 in_q;
    logic                 done_q;
    logic [X_W-1:0]       x_q;
    logic [Y_W-1:0]       y_q;
    logic [ADDR_W-1:0]    addr_q;

    // The FSM is already idle while the delayed done is shown; a start then is refused
    // so busy still drops for a cycle between frames.
    assign start_ok  = start & ~done_q;
    // The last pixel sits in the delay stage during DONE and must be consumed first.
    assign done_exit = ready;
`else
    logic                 plot_r;
    logic                 done_r;

    assign start_ok  = start;
    assign done_exit = 1'b1;
`endif

    // State register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= S_IDLE;
        else         state <= state_next;
    end

    // Next-state logic; abort beats start and beats a pending advance
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (start_ok && !abort) state_next = S_SCAN;
            S_SCAN:  if (abort) state_next = S_IDLE;
                     else if (ready && last_px) state_next = S_DONE;
            S_DONE:  if (abort || done_exit) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Pixel counters: zeroed in/into IDLE, advanced on each accepted non-final pixel
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_x     <= '0;
            cnt_y     <= '0;
            cnt_addr  <= '0;
            cnt_strip <= '0;
            cnt_in    <= 1'b0;
        end else if (state_next == S_IDLE) begin
            cnt_x     <= '0;
            cnt_y     <= '0;
            cnt_addr  <= '0;
            cnt_strip <= '0;
            cnt_in    <= 1'b0;
        end else if (state == S_IDLE) begin
            cnt_x     <= '0;
            cnt_y     <= '0;
            cnt_addr  <= '0;
            cnt_strip <= '0;
            cnt_in    <= SPLIT_TOP;
        end else if (state == S_SCAN && state_next == S_SCAN && ready) begin
            if (cnt_x == X_LAST) begin
                cnt_x  <= '0;
                cnt_y  <= cnt_y + Y_ONE;
                cnt_in <= cnt_in | (!SPLIT_TOP && cnt_y == Y_PRE_SPLIT);
            end else begin
                cnt_x  <= cnt_x + X_ONE;
            end
            cnt_addr <= cnt_addr + A_ONE;
            if (cnt_in) cnt_strip <= cnt_strip + S_ONE;
        end
    end

    // Busy flag registered from the next state
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) busy_r <= 1'b0;
        else         busy_r <= (state_next != S_IDLE);
    end

`ifdef RASTER_SCAN_ROM_ALIGN_EN
    // Delay stage: moves with the counters under back-pressure, zeros outside SCAN
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            plot_q <= 1'b0;
            in_q   <= 1'b0;
            done_q <= 1'b0;
            x_q    <= '0;
            y_q    <= '0;
            addr_q <= '0;
        end else if (abort && state != S_IDLE) begin
            plot_q <= 1'b0;
            in_q   <= 1'b0;
            done_q <= 1'b0;
            x_q    <= '0;
            y_q    <= '0;
            addr_q <= '0;
        end else begin
            done_q <= (state == S_DONE) && ready;
            if (ready || state == S_IDLE) begin
                plot_q <= (state == S_SCAN);
                in_q   <= (state == S_SCAN) && cnt_in;
                x_q    <= (state == S_SCAN) ? cnt_x    : '0;
                y_q    <= (state == S_SCAN) ? cnt_y    : '0;
                addr_q <= (state == S_SCAN) ? cnt_addr : '0;
            end
        end
    end

    assign plot       = plot_q;
    assign x          = x_q;
    assign y          = y_q;
    assign addr       = addr_q;
    assign in_strip   = in_q;
    assign strip_addr = cnt_strip;
    assign done       = done_q;
    assign busy       = busy_r | done_q;
`else
    // Plot and done flags registered from the next state
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            plot_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            plot_r <= (state_next == S_SCAN);
            done_r <= (state_next == S_DONE);
        end
    end

    assign plot       = plot_r;
    assign x          = cnt_x;
    assign y          = cnt_y;
    assign addr       = cnt_addr;
    assign in_strip   = cnt_in;
    assign strip_addr = cnt_strip;
    assign done       = done_r;
    assign busy       = busy_r;
`endif

endmodule

// File: tb/tb_raster_scan_engine.sv
// tb/tb_raster_scan_engine.sv - randomized self-checking bench for raster_scan_engine
`timescale 1ns/1ps
module tb_raster_scan_engine;

    localparam int H  = 160;
    localparam int V  = 120;
    localparam int S  = 92;
    localparam int N  = H * V;
    localparam int SH = 4;
    localparam int SV = 3;
    localparam int SS = 2;
    localparam int SN = SH * SV;
`ifdef RASTER_SCAN_ROM_ALIGN_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 0;
`endif

    logic        clk = 1'b0;
    logic        resetn, start, abort, ready;
    logic        busy, plot, in_strip, done;
    logic [7:0]  x;
    logic [6:0]  y;
    logic [14:0] addr;
    logic [12:0] strip_addr;

    logic        s_start, s_abort, s_ready;
    logic        s_busy, s_plot, s_in_strip, s_done;
    logic [1:0]  s_x, s_y, s_strip;
    logic [3:0]  s_addr;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    raster_scan_engine dut (
        .clk(clk), .resetn(resetn), .start(start), .abort(abort), .ready(ready),
        .busy(busy), .plot(plot), .x(x), .y(y), .addr(addr),
        .in_strip(in_strip), .strip_addr(strip_addr), .done(done)
    );

    raster_scan_engine #(
        .H_RES(SH), .V_RES(SV), .X_W(2), .Y_W(2), .ADDR_W(4), .SPLIT_Y(SS), .STRIP_W(2)
    ) dut_s (
        .clk(clk), .resetn(resetn), .start(s_start), .abort(s_abort), .ready(s_ready),
        .busy(s_busy), .plot(s_plot), .x(s_x), .y(s_y), .addr(s_addr),
        .in_strip(s_in_strip), .strip_addr(s_strip), .done(s_done)
    );

    function automatic int exp_strip(input int k, input int h, input int s);
        int row;
        row = k / h;
        return (row >= s) ? (k - s * h) : 0;
    endfunction

    task automatic test_reset();
        resetn = 1'b0; start = 1'b0; abort = 1'b0; ready = 1'b0;
        s_start = 1'b0; s_abort = 1'b0; s_ready = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, plot, done, in_strip, x, y, addr, strip_addr} !== '0) begin
            errors++;
            $display("FAIL reset_state: got busy=%b plot=%b done=%b x=%0d y=%0d addr=%0d, want all 0",
                     busy, plot, done, x, y, addr);
        end
        resetn = 1'b1;
        @(negedge clk); start = 1'b1; ready = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (20) @(negedge clk);
        #1 resetn = 1'b0;
        #1;
        checks++;
        if ({busy, plot, done, in_strip, x, y, addr, strip_addr} !== '0) begin
            errors++;
            $display("FAIL async_reset: got busy=%b plot=%b x=%0d addr=%0d, want all 0", busy, plot, x, addr);
        end
        @(negedge clk); resetn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_sweep(input bit rnd, input string tag);
        int k, cyc, plots, dones, done_cyc, last_strip, want_strip, got_strip;
        bit fin;
        k = 0; cyc = 0; plots = 0; dones = 0; done_cyc = -1; last_strip = -1; fin = 1'b0;
        @(negedge clk); start = 1'b1; ready = 1'b1;
        @(negedge clk); start = 1'b0; cyc = 1;
        while (!fin && cyc < 60000) begin
            if (plot === 1'b1) begin
                plots++;
                checks++;
                if (x !== 8'(k % H) || y !== 7'(k / H) || addr !== 15'(k) ||
                    in_strip !== ((k / H) >= S) || busy !== 1'b1) begin
                    errors++;
                    $display("FAIL %s pixel %0d: got x=%0d y=%0d addr=%0d in_strip=%b busy=%b, want x=%0d y=%0d addr=%0d in_strip=%b busy=1",
                             tag, k, x, y, addr, in_strip, busy, k % H, k / H, k, (k / H) >= S);
                end
                want_strip = exp_strip(k, H, S);
`ifdef RASTER_SCAN_ROM_ALIGN_EN
                got_strip = last_strip;
`else
                got_strip = int'(strip_addr);
`endif
                checks++;
                if (got_strip != want_strip) begin
                    errors++;
                    $display("FAIL %s strip pixel %0d: got %0d want %0d", tag, k, got_strip, want_strip);
                end
            end
            if (done === 1'b1) begin
                dones++; done_cyc = cyc;
                checks++;
                if (k != N || plot !== 1'b0 || busy !== 1'b1) begin
                    errors++;
                    $display("FAIL %s done_cycle: got accepted=%0d plot=%b busy=%b, want %0d 0 1", tag, k, plot, busy, N);
                end
            end else if (dones > 0) begin
                fin = 1'b1;
                checks++;
                if ({busy, plot, in_strip, x, y, addr, strip_addr} !== '0) begin
                    errors++;
                    $display("FAIL %s after_done: got busy=%b plot=%b x=%0d addr=%0d, want all 0", tag, busy, plot, x, addr);
                end
            end
            if (!fin) begin
                ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
                if (plot === 1'b1 && ready) k++;
                if (ready) last_strip = int'(strip_addr);
                @(negedge clk);
                cyc++;
            end
        end
        checks++;
        if (!fin) begin errors++; $display("FAIL %s timeout: got %0d cycles, want frame end", tag, cyc); end
        checks++;
        if (dones != 1) begin errors++; $display("FAIL %s done_len: got %0d want 1", tag, dones); end
        if (!rnd) begin
            checks++;
            if (plots != N || done_cyc != N + 1 + LAT) begin
                errors++;
                $display("FAIL %s frame_len: got plots=%0d done_at=%0d, want %0d %0d", tag, plots, done_cyc, N, N + 1 + LAT);
            end
        end
        ready = 1'b1;
    endtask

    task automatic test_abort();
        bit hit, seen;
        hit = 1'b0; seen = 1'b0;
        @(negedge clk); start = 1'b1; ready = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int i = 0; i < 2000 && !hit; i++) begin
            if (plot === 1'b1 && x == 8'd10 && y == 7'd5) hit = 1'b1;
            else @(negedge clk);
        end
        checks++;
        if (!hit) begin errors++; $display("FAIL abort_reach: got no pixel (10,5), want it"); end
        abort = 1'b1;
        @(negedge clk); abort = 1'b0;
        checks++;
        if ({busy, plot, done, in_strip, x, y, addr, strip_addr} !== '0) begin
            errors++;
            $display("FAIL abort_clear: got busy=%b plot=%b done=%b x=%0d y=%0d addr=%0d, want all 0",
                     busy, plot, done, x, y, addr);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL abort_idle: got done=%b busy=%b, want 0 0", done, busy);
            end
        end
        start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int i = 0; i < 3 && !seen; i++) begin
            if (plot === 1'b1) seen = 1'b1;
            else @(negedge clk);
        end
        checks++;
        if (!seen || x !== 8'd0 || y !== 7'd0 || addr !== 15'd0) begin
            errors++;
            $display("FAIL abort_restart: got plot_seen=%b x=%0d y=%0d addr=%0d, want 1 0 0 0", seen, x, y, addr);
        end
        abort = 1'b1;
        @(negedge clk); abort = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_small_params(input bit rnd);
        int k, cyc, plots, first_cyc, done_cyc, last_strip, got_strip;
        k = 0; cyc = 0; plots = 0; first_cyc = -1; done_cyc = -1; last_strip = -1;
        @(negedge clk); s_start = 1'b1; s_ready = 1'b1;
        @(negedge clk); s_start = 1'b0; cyc = 1;
        while (done_cyc < 0 && cyc < 200) begin
            if (s_plot === 1'b1) begin
                plots++;
                if (first_cyc < 0) first_cyc = cyc;
`ifdef RASTER_SCAN_ROM_ALIGN_EN
                got_strip = last_strip;
`else
                got_strip = int'(s_strip);
`endif
                checks++;
                if (s_x !== 2'(k % SH) || s_y !== 2'(k / SH) || s_addr !== 4'(k) ||
                    s_in_strip !== ((k / SH) >= SS) || got_strip != exp_strip(k, SH, SS)) begin
                    errors++;
                    $display("FAIL small pixel %0d: got x=%0d y=%0d addr=%0d in=%b strip=%0d, want %0d %0d %0d %b %0d",
                             k, s_x, s_y, s_addr, s_in_strip, got_strip,
                             k % SH, k / SH, k, (k / SH) >= SS, exp_strip(k, SH, SS));
                end
            end
            if (s_done === 1'b1) done_cyc = cyc;
            else begin
                s_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
                if (s_plot === 1'b1 && s_ready) k++;
                if (s_ready) last_strip = int'(s_strip);
                @(negedge clk);
                cyc++;
            end
        end
        checks++;
        if (done_cyc < 0 || k != SN) begin
            errors++;
            $display("FAIL small_count: got accepted=%0d done_at=%0d, want %0d and a done", k, done_cyc, SN);
        end
        if (!rnd) begin
            checks++;
            if (first_cyc != 1 + LAT || done_cyc != SN + 1 + LAT || plots != SN) begin
                errors++;
                $display("FAIL small_timing: got first=%0d done=%0d plots=%0d, want %0d %0d %0d",
                         first_cyc, done_cyc, plots, 1 + LAT, SN + 1 + LAT, SN);
            end
        end
        @(negedge clk);
        checks++;
        if (s_done !== 1'b0 || s_busy !== 1'b0) begin
            errors++;
            $display("FAIL small_after_done: got done=%b busy=%b, want 0 0", s_done, s_busy);
        end
        s_ready = 1'b1;
    endtask

    task automatic test_start_held();
        int cyc, plots, done_cyc;
        bit seen;
        cyc = 0; plots = 0; done_cyc = -1; seen = 1'b0;
        @(negedge clk); s_start = 1'b1; s_ready = 1'b1;
        @(negedge clk); cyc = 1;
        while (done_cyc < 0 && cyc < 100) begin
            if (s_plot === 1'b1) plots++;
            if (s_done === 1'b1) done_cyc = cyc;
            else begin @(negedge clk); cyc++; end
        end
        checks++;
        if (plots != SN || done_cyc != SN + 1 + LAT) begin
            errors++;
            $display("FAIL held_frame: got plots=%0d done_at=%0d, want %0d %0d", plots, done_cyc, SN, SN + 1 + LAT);
        end
        @(negedge clk);
        checks++;
        if (s_done !== 1'b0 || s_busy !== 1'b0) begin
            errors++;
            $display("FAIL held_gap: got done=%b busy=%b, want 0 0", s_done, s_busy);
        end
        @(negedge clk);
        checks++;
        if (s_busy !== 1'b1) begin errors++; $display("FAIL held_restart_busy: got %b want 1", s_busy); end
        for (int i = 0; i < 3 && !seen; i++) begin
            if (s_plot === 1'b1) seen = 1'b1;
            else @(negedge clk);
        end
        checks++;
        if (!seen || s_x !== 2'd0 || s_y !== 2'd0 || s_addr !== 4'd0) begin
            errors++;
            $display("FAIL held_second_frame: got seen=%b x=%0d y=%0d addr=%0d, want 1 0 0 0", seen, s_x, s_y, s_addr);
        end
        s_start = 1'b0; s_abort = 1'b1;
        @(negedge clk); s_abort = 1'b0;
        checks++;
        if (s_busy !== 1'b0 || s_plot !== 1'b0) begin
            errors++;
            $display("FAIL held_abort: got busy=%b plot=%b, want 0 0", s_busy, s_plot);
        end
        s_start = 1'b1; s_abort = 1'b1;
        @(negedge clk); s_start = 1'b0; s_abort = 1'b0;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (s_busy !== 1'b0 || s_plot !== 1'b0) begin
                errors++;
                $display("FAIL start_abort_idle: got busy=%b plot=%b, want 0 0", s_busy, s_plot);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_sweep(1'b0, "full_frame");
        test_sweep(1'b1, "random_ready");
        test_abort();
        test_small_params(1'b0);
        test_small_params(1'b1);
        test_start_held();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
